// File: rtl/stage_sync_controller_multi_if.sv
// Stage bus between the multi-partition stage controller and its neighbours.
// master drives round start and local/peer flags; slave is the controller.
interface stage_sync_controller_multi_if #(
  parameter int NUM_PEERS               = 2,
  parameter int ITERATION_COUNTER_WIDTH = 8,
  parameter int STAGE_WIDTH             = 3
);
  logic                               new_round_start;
  logic                               has_message_flying;
  logic                               has_odd_clusters;
  logic [NUM_PEERS-1:0]               peer_has_message_flying;
  logic [NUM_PEERS-1:0]               peer_has_odd_clusters;
  logic [NUM_PEERS-1:0]               peer_enable;
  logic [STAGE_WIDTH-1:0]             stage;
  logic                               result_valid;
  logic [ITERATION_COUNTER_WIDTH-1:0] iteration_counter;
  logic [31:0]                        cycle_counter;
  logic                               iteration_limit_hit;
  logic                               deadlock;

  modport master (
    output new_round_start, has_message_flying, has_odd_clusters,
    output peer_has_message_flying, peer_has_odd_clusters, peer_enable,
    input  stage, result_valid, iteration_counter, cycle_counter,
    input  iteration_limit_hit, deadlock
  );

  modport slave (
    input  new_round_start, has_message_flying, has_odd_clusters,
    input  peer_has_message_flying, peer_has_odd_clusters, peer_enable,
    output stage, result_valid, iteration_counter, cycle_counter,
    output iteration_limit_hit, deadlock
  );
endinterface

// File: rtl/stage_sync_controller_multi.sv
// Round sequencer for a decoder split over one local and NUM_PEERS peer partitions.
// Ports: clk, reset (sync, active-high), bus (stage bus, slave side).
// Optional merge watchdog: define STAGE_SYNC_WATCHDOG_EN.
module stage_sync_controller_multi #(
  parameter int NUM_PEERS               = 2,
  parameter int ITERATION_COUNTER_WIDTH = 8,
  parameter int MAX_ITERATIONS          = 16,
  parameter int MERGE_SETTLE_CYCLES     = 4,
  parameter int DEADLOCK_CYCLES         = 1024,
  parameter int STAGE_WIDTH             = 3
) (
  input logic clk,
  input logic reset,
  stage_sync_controller_multi_if.slave bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_GROW  = 3'd2;
  localparam logic [2:0] S_MERGE = 3'd3;
  localparam logic [2:0] S_RV    = 3'd4;

  localparam int ICW = ITERATION_COUNTER_WIDTH;
  localparam int QW  = $clog2(MERGE_SETTLE_CYCLES + 1);

  localparam logic [ICW-1:0] ITER_MAX = ICW'(MAX_ITERATIONS);
  localparam logic [ICW-1:0] ITER_SAT = {ICW{1'b1}};
  localparam logic [QW-1:0]  Q_LAST   = QW'(MERGE_SETTLE_CYCLES - 1);

  logic [2:0]           st;
  logic [NUM_PEERS-1:0] pf_q;
  logic [NUM_PEERS-1:0] po_q;
  logic [QW-1:0]        quiet_count;
  logic [ICW-1:0]       iter;
  logic [31:0]          cyc;
  logic                 lim;
  logic                 flying;
  logic                 odd;
  logic                 settled;

  // Peer flags arrive registered; local flags are used as-is.
  assign flying  = bus.has_message_flying | (|pf_q);
  assign odd     = bus.has_odd_clusters | (|po_q);
  assign settled = !flying && (quiet_count == Q_LAST);

`ifdef STAGE_SYNC_WATCHDOG_EN
  localparam int MCW = $clog2(DEADLOCK_CYCLES + 1);
  localparam logic [MCW-1:0] M_LAST = MCW'(DEADLOCK_CYCLES - 1);

  logic [MCW-1:0] merge_count;
  logic           dl;
  logic           wd_fire;

  assign wd_fire = (merge_count == M_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      merge_count <= '0;
      dl          <= 1'b0;
    end else begin
      unique case (st)
        S_IDLE: begin
          if (bus.new_round_start)
            dl <= 1'b0;
        end
        S_GROW:  merge_count <= '0;
        S_MERGE: begin
          merge_count <= merge_count + 1'b1;
          if (wd_fire)
            dl <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.deadlock = dl;
`else
  logic wd_fire;
  wire  unused_dl_cycles = (DEADLOCK_CYCLES != 0);

  assign wd_fire      = 1'b0;
  assign bus.deadlock = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      st          <= S_IDLE;
      pf_q        <= '0;
      po_q        <= '0;
      quiet_count <= '0;
      iter        <= '0;
      cyc         <= '0;
      lim         <= 1'b0;
    end else begin
      pf_q <= bus.peer_has_message_flying & bus.peer_enable;
      po_q <= bus.peer_has_odd_clusters & bus.peer_enable;

      if (st != S_IDLE && cyc != 32'hFFFF_FFFF)
        cyc <= cyc + 32'd1;

      unique case (st)
        S_IDLE: begin
          if (bus.new_round_start) begin
            st   <= S_LOAD;
            iter <= '0;
            cyc  <= '0;
            lim  <= 1'b0;
          end
        end
        S_LOAD: st <= S_GROW;
        S_GROW: begin
          st          <= S_MERGE;
          quiet_count <= '0;
          if (iter != ITER_SAT)
            iter <= iter + 1'b1;
        end
        S_MERGE: begin
          quiet_count <= flying ? '0 : quiet_count + 1'b1;
          // Watchdog outranks a normal exit in the same cycle.
          if (wd_fire) begin
            st <= S_RV;
          end else if (settled) begin
            if (!odd) begin
              st <= S_RV;
            end else if (iter >= ITER_MAX) begin
              st  <= S_RV;
              lim <= 1'b1;
            end else begin
              st <= S_GROW;
            end
          end
        end
        S_RV:    st <= S_IDLE;
        default: st <= S_IDLE;
      endcase
    end
  end

  assign bus.stage               = STAGE_WIDTH'(st);
  assign bus.result_valid        = (st == S_RV);
  assign bus.iteration_counter   = iter;
  assign bus.cycle_counter       = cyc;
  assign bus.iteration_limit_hit = lim;
endmodule

// File: tb/tb_stage_sync_controller_multi.sv
// Randomised round-level bench for stage_sync_controller_multi.
// Predicts merge lengths, iteration counts and round length from round rules.
module tb_stage_sync_controller_multi;
  localparam int NP   = 2;
  localparam int ICW  = 8;
  localparam int MAXI = 16;
  localparam int SET  = 4;
  localparam int DL   = 32;
  localparam int SW   = 3;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  stage_sync_controller_multi_if #(
    .NUM_PEERS(NP),
    .ITERATION_COUNTER_WIDTH(ICW),
    .STAGE_WIDTH(SW)
  ) bus ();

  stage_sync_controller_multi #(
    .NUM_PEERS(NP),
    .ITERATION_COUNTER_WIDTH(ICW),
    .MAX_ITERATIONS(MAXI),
    .MERGE_SETTLE_CYCLES(SET),
    .DEADLOCK_CYCLES(DL),
    .STAGE_WIDTH(SW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic idle_inputs();
    bus.new_round_start         = 1'b0;
    bus.has_message_flying      = 1'b0;
    bus.has_odd_clusters        = 1'b0;
    bus.peer_has_message_flying = '0;
    bus.peer_has_odd_clusters   = '0;
    bus.peer_enable             = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stage"}, 32'(bus.stage), 0);
    chk({tag, "_rv"}, 32'(bus.result_valid), 0);
    chk({tag, "_iter"}, 32'(bus.iteration_counter), 0);
    chk({tag, "_cyc"}, bus.cycle_counter, 0);
    chk({tag, "_lim"}, 32'(bus.iteration_limit_hit), 0);
    chk({tag, "_dl"}, 32'(bus.deadlock), 0);
  endtask

  // n_odd: number of leading merge exits that see odd clusters.
  // When rnd=0 every phase uses flying length fl from source fsrc
  // (0 = local, k = peer k-1) with peer_enable fen.
  task automatic run_round(input int n_odd, input bit rnd, input int fl,
                           input int fsrc, input int fen);
    int s, m, phase, cyc, len_exp, sum_exp, grows, src, fl_len, j;
    int ph_exp;
    bit done, odd, fly, lim_exp;
    logic [NP-1:0] en;
    m = 0; phase = 1; cyc = 1; sum_exp = 0; grows = 0;
    src = 0; fl_len = 0; len_exp = 0; done = 1'b0;
    ph_exp  = (n_odd >= MAXI) ? MAXI : n_odd + 1;
    lim_exp = (n_odd >= MAXI);
    idle_inputs();
    @(negedge clk);
    bus.new_round_start = 1'b1;
    @(negedge clk);
    while (!done && cyc < 3000) begin
      s = int'(bus.stage);
      if (s != 3 && m > 0) begin
        chk("merge_len", m, len_exp);
        m = 0;
        phase++;
      end
      bus.new_round_start         = 1'b0;
      bus.has_message_flying      = 1'b0;
      bus.peer_has_message_flying = '0;
      if (cyc == 1) chk("load_stage", s, 1);
      if (s == 2) begin
        grows++;
      end else if (s == 3) begin
        m++;
        if (m == 1) begin
          odd = (phase <= n_odd);
          bus.has_odd_clusters      = 1'b0;
          bus.peer_has_odd_clusters = '0;
          if (rnd) begin
            src    = $urandom_range(0, NP);
            fl_len = $urandom_range(0, 6);
            en     = NP'($urandom_range(0, (1 << NP) - 1));
          end else begin
            src    = fsrc;
            fl_len = fl;
            en     = NP'(fen);
          end
          bus.peer_enable = en;
          if (odd) begin
            if (rnd && $urandom_range(0, 1) == 1) begin
              j = $urandom_range(0, NP - 1);
              bus.peer_enable[j]           = 1'b1;
              bus.peer_has_odd_clusters[j] = 1'b1;
            end else begin
              bus.has_odd_clusters = 1'b1;
            end
          end else if (rnd) begin
            bus.peer_has_odd_clusters = ~bus.peer_enable;
          end
          if (src == 0)
            len_exp = fl_len + SET;
          else if (bus.peer_enable[src-1] && fl_len > 0)
            len_exp = fl_len + 1 + SET;
          else
            len_exp = SET;
          sum_exp += len_exp;
        end
        fly = (m <= fl_len);
        if (src == 0) bus.has_message_flying = fly;
        else bus.peer_has_message_flying[src-1] = fly;
        if (rnd) bus.new_round_start = ($urandom_range(0, 7) == 0);
      end else if (s == 4) begin
        chk("rv_pulse", 32'(bus.result_valid), 1);
        chk("rv_cycle", cyc, 2 + ph_exp + sum_exp);
        chk("grows", grows, ph_exp);
        chk("iter", 32'(bus.iteration_counter), ph_exp);
        chk("limit", 32'(bus.iteration_limit_hit), 32'(lim_exp));
        chk("deadlock", 32'(bus.deadlock), 0);
        done = 1'b1;
      end else if (s != 1) begin
        chk("bad_stage", s, 4);
        done = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    if (!done) chk("round_timeout", 0, 1);
    chk("end_stage", 32'(bus.stage), 0);
    chk("end_rv", 32'(bus.result_valid), 0);
    chk("end_cyc", bus.cycle_counter, 2 + ph_exp + sum_exp);
    chk("end_limit", 32'(bus.iteration_limit_hit), 32'(lim_exp));
    idle_inputs();
  endtask

  initial begin
    int k, n;
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_zero("reset");

    run_round(0, 1'b0, 0, 0, 0);
    run_round(0, 1'b0, 10, 2, 3);
    run_round(0, 1'b0, 10, 2, 1);
    run_round(2, 1'b0, 0, 0, 0);
    run_round(100, 1'b0, 0, 0, 0);

    for (int r = 0; r < 25; r++) begin
      n = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3);
      run_round(n, 1'b1, 0, 0, 0);
    end

    // Reset in the middle of GROW.
    @(negedge clk);
    bus.new_round_start = 1'b1;
    @(negedge clk);
    bus.new_round_start = 1'b0;
    k = 0;
    while (int'(bus.stage) != 2 && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("grow_reached", 32'(bus.stage), 2);
    bus.peer_enable = '1;
    bus.peer_has_message_flying = '1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    chk_zero("mid_reset");
    run_round(1, 1'b0, 2, 1, 1);

    // Flying stuck high inside MERGE.
    @(negedge clk);
    bus.new_round_start = 1'b1;
    @(negedge clk);
    bus.new_round_start = 1'b0;
    bus.has_message_flying = 1'b1;
    k = 0;
    while (int'(bus.stage) != 3 && k < 10) begin
      @(negedge clk);
      k++;
    end
`ifdef STAGE_SYNC_WATCHDOG_EN
    k = 0;
    while (int'(bus.stage) == 3 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("wd_merge_cycles", k, DL);
    chk("wd_stage", 32'(bus.stage), 4);
    chk("wd_deadlock", 32'(bus.deadlock), 1);
    idle_inputs();
    run_round(0, 1'b0, 0, 0, 0);
`else
    k = 0;
    while (int'(bus.stage) == 3 && k < 1100) begin
      @(negedge clk);
      k++;
    end
    chk("stuck_cycles", k, 1100);
    chk("stuck_stage", 32'(bus.stage), 3);
    chk("stuck_deadlock", 32'(bus.deadlock), 0);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_zero("stuck_reset");
    run_round(0, 1'b0, 0, 0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
